// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO controller slice.
package gpio_pkg;

    localparam int GPIO_WIDTH_DEF      = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    typedef logic [GPIO_WIDTH_DEF-1:0] gpio_vec_t;

endpackage : gpio_pkg

// File: rtl/gpio_debounce_bit.sv
// One GPIO line: 2-FF synchroniser, debounce counter, and rise/fall pulses
// aligned with the first cycle the accepted level appears on stable_o.
module gpio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_r;
    logic                 sync2_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 stable_r;
    logic                 rise_r;
    logic                 fall_r;

    // Synchronise the pad, count consecutive disagreeing samples, accept the
    // new level after DEBOUNCE_CYCLES of them and pulse the matching edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            cnt_r    <= CNT_ZERO;
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            sync1_r <= pad_i;
            sync2_r <= sync1_r;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            if (sync2_r == stable_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                // Saturation point: accept the level and restart from zero.
                stable_r <= sync2_r;
                cnt_r    <= CNT_ZERO;
                rise_r   <= sync2_r;
                fall_r   <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign stable_o = stable_r;
    assign rise_o   = rise_r;
    assign fall_o   = fall_r;

endmodule : gpio_debounce_bit

// File: rtl/gpio_input_conditioner.sv
// Conditions raw GPIO pads for the controller: per-bit synchronise and
// debounce, edge pulses, sticky W1C pending flags and a level interrupt.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH      = GPIO_WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [GPIO_WIDTH-1:0] pad_i,
    output logic [GPIO_WIDTH-1:0] filt_data_o,
    output logic [GPIO_WIDTH-1:0] rise_o,
    output logic [GPIO_WIDTH-1:0] fall_o,
    input  logic [GPIO_WIDTH-1:0] rise_en_i,
    input  logic [GPIO_WIDTH-1:0] fall_en_i,
    input  logic [GPIO_WIDTH-1:0] pend_clr_i,
    output logic [GPIO_WIDTH-1:0] pend_o,
    output logic                  irq_o
);

    logic [GPIO_WIDTH-1:0] stable_s;
    logic [GPIO_WIDTH-1:0] rise_s;
    logic [GPIO_WIDTH-1:0] fall_s;
    logic [GPIO_WIDTH-1:0] set_s;
    logic [GPIO_WIDTH-1:0] pend_r;
    logic                  irq_r;

    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .pad_i   (pad_i[gi]),
            .stable_o(stable_s[gi]),
            .rise_o  (rise_s[gi]),
            .fall_o  (fall_s[gi])
        );
    end

    // Enabled edge events that should raise a pending flag this cycle.
    always_comb begin
        set_s = {GPIO_WIDTH{1'b0}};
        set_s = (rise_s & rise_en_i) | (fall_s & fall_en_i);
    end

    // Sticky pending flags; a new event wins over a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_r <= {GPIO_WIDTH{1'b0}};
        end else begin
            pend_r <= set_s | (pend_r & ~pend_clr_i);
        end
    end

    // Level interrupt follows the pending flags one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |pend_r;
        end
    end

    assign filt_data_o = stable_s;
    assign rise_o      = rise_s;
    assign fall_o      = fall_s;
    assign pend_o      = pend_r;
    assign irq_o       = irq_r;

endmodule : gpio_input_conditioner

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: two instances (16-cycle and 1-cycle
// debounce) share stimulus; a window-based model predicts every output.
module tb_gpio_input_conditioner;

    localparam int W    = 8;
    localparam int HLEN = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pad = '0;
    logic [W-1:0] rise_en = '0;
    logic [W-1:0] fall_en = '0;
    logic [W-1:0] clr = '0;

    logic [W-1:0] filt_s [2];
    logic [W-1:0] rise_s [2];
    logic [W-1:0] fall_s [2];
    logic [W-1:0] pend_s [2];
    logic         irq_s  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_input_conditioner #(.GPIO_WIDTH(W), .DEBOUNCE_CYCLES(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .pad_i(pad),
        .filt_data_o(filt_s[0]), .rise_o(rise_s[0]), .fall_o(fall_s[0]),
        .rise_en_i(rise_en), .fall_en_i(fall_en), .pend_clr_i(clr),
        .pend_o(pend_s[0]), .irq_o(irq_s[0])
    );

    gpio_input_conditioner #(.GPIO_WIDTH(W), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .pad_i(pad),
        .filt_data_o(filt_s[1]), .rise_o(rise_s[1]), .fall_o(fall_s[1]),
        .rise_en_i(rise_en), .fall_en_i(fall_en), .pend_clr_i(clr),
        .pend_o(pend_s[1]), .irq_o(irq_s[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level is accepted once the synchronised input (pad two edges
    // earlier) has shown the opposite value for the last D consecutive edges.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_filt [2];
    logic [W-1:0] m_rise [2];
    logic [W-1:0] m_fall [2];
    logic [W-1:0] m_pend [2];
    logic         m_irq  [2];

    function automatic int dbc(input int k);
        return (k == 0) ? 16 : 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            for (int i = 0; i < HLEN; i++) hist.push_back('0);
            for (int k = 0; k < 2; k++) begin
                m_filt[k] = '0; m_rise[k] = '0; m_fall[k] = '0;
                m_pend[k] = '0; m_irq[k] = 1'b0;
            end
        end else begin
            hist.push_back(pad);
            void'(hist.pop_front());
            for (int k = 0; k < 2; k++) begin
                logic [W-1:0] o_rise, o_fall, o_pend;
                o_rise = m_rise[k]; o_fall = m_fall[k]; o_pend = m_pend[k];
                m_rise[k] = '0; m_fall[k] = '0;
                for (int b = 0; b < W; b++) begin
                    bit agree;
                    agree = 1'b1;
                    for (int j = HLEN - 2 - dbc(k); j < HLEN - 2; j++)
                        if (hist[j][b] == m_filt[k][b]) agree = 1'b0;
                    if (agree) begin
                        m_filt[k][b] = ~m_filt[k][b];
                        if (m_filt[k][b]) m_rise[k][b] = 1'b1;
                        else              m_fall[k][b] = 1'b1;
                    end
                end
                m_pend[k] = (o_rise & rise_en) | (o_fall & fall_en) | (o_pend & ~clr);
                m_irq[k]  = |o_pend;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("d%0d_filt", k), 32'(filt_s[k]), 32'(m_filt[k]));
                chk($sformatf("d%0d_rise", k), 32'(rise_s[k]), 32'(m_rise[k]));
                chk($sformatf("d%0d_fall", k), 32'(fall_s[k]), 32'(m_fall[k]));
                chk($sformatf("d%0d_pend", k), 32'(pend_s[k]), 32'(m_pend[k]));
                chk($sformatf("d%0d_irq", k),  32'(irq_s[k]),  32'(m_irq[k]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr(input logic [W-1:0] v);
        clr = v;
        cyc(1);
        clr = '0;
    endtask

    initial begin
        // Reset, then build up nonzero state, then reset mid-count.
        cyc(3);
        rst = 1'b0;
        pad = 8'hFF; rise_en = 8'hFF; fall_en = 8'hFF;
        cyc(25);
        chk("lit_pre_rst_filt", 32'(filt_s[0]), 32'h0000_00FF);
        chk("lit_pre_rst_irq",  32'(irq_s[0]),  32'h0000_0001);
        pad = 8'h00;
        cyc(8);
        pad = 8'hFF;
        cyc(3);
        #2 rst = 1'b1;
        #1;
        chk("lit_rst_filt", 32'(filt_s[0]), 32'h0);
        chk("lit_rst_pend", 32'(pend_s[0]), 32'h0);
        chk("lit_rst_irq",  32'(irq_s[0]),  32'h0);
        chk("lit_rst_pend1", 32'(pend_s[1]), 32'h0);
        cyc(3);
        rst = 1'b0;
        // Pad held high through reset release: rise at 2+D edges.
        cyc(17);
        chk("lit_pwrup_17", 32'(filt_s[0]), 32'h0);
        cyc(1);
        chk("lit_pwrup_18", 32'(filt_s[0]), 32'h0000_00FF);
        chk("lit_pwrup_rise", 32'(rise_s[0]), 32'h0000_00FF);
        pad = 8'h00;
        cyc(40);
        pulse_clr(8'hFF);
        rise_en = '0; fall_en = '0;
        cyc(3);

        // Clean step on bit 3.
        pad[3] = 1'b1;
        cyc(2);
        chk("lit_step_d1_e2", 32'(filt_s[1][3]), 32'h0);
        cyc(1);
        chk("lit_step_d1_e3", 32'(rise_s[1][3]), 32'h1);
        cyc(14);
        chk("lit_step_e17", 32'(filt_s[0][3]), 32'h0);
        cyc(1);
        chk("lit_step_e18_filt", 32'(filt_s[0][3]), 32'h1);
        chk("lit_step_e18_rise", 32'(rise_s[0][3]), 32'h1);
        cyc(1);
        chk("lit_step_e19_rise", 32'(rise_s[0][3]), 32'h0);
        pad[3] = 1'b0;
        cyc(40);

        // Glitches: 15 cycles rejected, 16 cycles accepted.
        pad[0] = 1'b1;
        cyc(15);
        pad[0] = 1'b0;
        cyc(40);
        chk("lit_glitch15", 32'(filt_s[0][0]), 32'h0);
        pad[0] = 1'b1;
        cyc(16);
        pad[0] = 1'b0;
        cyc(2);
        chk("lit_glitch16_rise", 32'(rise_s[0][0]), 32'h1);
        cyc(16);
        chk("lit_glitch16_fall", 32'(fall_s[0][0]), 32'h1);
        chk("lit_glitch16_filt", 32'(filt_s[0][0]), 32'h0);
        cyc(40);

        // Pending flag and interrupt.
        pulse_clr(8'hFF);
        rise_en = 8'h01; fall_en = 8'h00;
        pad[0] = 1'b1;
        cyc(19);
        chk("lit_pend_set", 32'(pend_s[0]), 32'h01);
        chk("lit_irq_lag", 32'(irq_s[0]), 32'h0);
        cyc(1);
        chk("lit_irq_set", 32'(irq_s[0]), 32'h1);
        pad[0] = 1'b0;
        cyc(40);
        chk("lit_pend_after_fall", 32'(pend_s[0]), 32'h01);
        pulse_clr(8'h01);
        chk("lit_pend_clr", 32'(pend_s[0]), 32'h0);
        chk("lit_irq_hold", 32'(irq_s[0]), 32'h1);
        cyc(1);
        chk("lit_irq_clr", 32'(irq_s[0]), 32'h0);

        // Set/clear collision for each instance.
        rise_en = 8'h04;
        pad[2] = 1'b1;
        cyc(18);
        pulse_clr(8'h04);
        chk("lit_collide_d16", 32'(pend_s[0][2]), 32'h1);
        pad[2] = 1'b0;
        cyc(40);
        pulse_clr(8'hFF);
        cyc(2);
        pad[2] = 1'b1;
        cyc(3);
        pulse_clr(8'h04);
        chk("lit_collide_d1", 32'(pend_s[1][2]), 32'h1);
        cyc(20);
        pad[2] = 1'b0;
        cyc(40);
        pulse_clr(8'hFF);

        // Independence: staggered steps on all bits.
        rise_en = 8'hFF; fall_en = 8'hFF;
        for (int c = 0; c < 40; c++) begin
            if (c < 16 && (c % 2) == 0) pad[c/2] = 1'b1;
            @(negedge clk);
            if (c + 1 == 18) chk("lit_indep_18", 32'(filt_s[0]), 32'h01);
            if (c + 1 == 22) chk("lit_indep_22", 32'(filt_s[0]), 32'h07);
        end
        pad = 8'h00;
        cyc(40);
        pulse_clr(8'hFF);
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gpio_input_conditioner
